// File: rtl/vscale_hasti_2to1_arbiter.sv
// Two-master to one-slave HASTI arbiter.
// Each master owns a one-entry request buffer so a request that loses
// arbitration (or arrives while the slave is stalled) is held and replayed
// from the buffer on a later cycle. Ties go round-robin.

package vscale_hasti_constants_pkg;

    localparam int unsigned HASTI_ADDR_WIDTH  = 32;
    localparam int unsigned HASTI_BUS_WIDTH   = 32;
    localparam int unsigned HASTI_SIZE_WIDTH  = 3;
    localparam int unsigned HASTI_BURST_WIDTH = 3;
    localparam int unsigned HASTI_PROT_WIDTH  = 4;
    localparam int unsigned HASTI_TRANS_WIDTH = 2;
    localparam int unsigned HASTI_RESP_WIDTH  = 1;

    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'd0;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'd2;
    localparam logic [HASTI_RESP_WIDTH-1:0]  HASTI_RESP_OKAY    = 1'b0;

endpackage

module vscale_hasti_2to1_arbiter
    import vscale_hasti_constants_pkg::*;
(
    input  logic                         hclk,
    input  logic                         reset,

    // master 0
    input  logic [HASTI_ADDR_WIDTH-1:0]  m0_haddr,
    input  logic                         m0_hwrite,
    input  logic [HASTI_SIZE_WIDTH-1:0]  m0_hsize,
    input  logic [HASTI_BURST_WIDTH-1:0] m0_hburst,
    input  logic [HASTI_PROT_WIDTH-1:0]  m0_hprot,
    input  logic                         m0_hmastlock,
    input  logic [HASTI_TRANS_WIDTH-1:0] m0_htrans,
    input  logic [HASTI_BUS_WIDTH-1:0]   m0_hwdata,
    output logic [HASTI_BUS_WIDTH-1:0]   m0_hrdata,
    output logic                         m0_hready,
    output logic [HASTI_RESP_WIDTH-1:0]  m0_hresp,

    // master 1
    input  logic [HASTI_ADDR_WIDTH-1:0]  m1_haddr,
    input  logic                         m1_hwrite,
    input  logic [HASTI_SIZE_WIDTH-1:0]  m1_hsize,
    input  logic [HASTI_BURST_WIDTH-1:0] m1_hburst,
    input  logic [HASTI_PROT_WIDTH-1:0]  m1_hprot,
    input  logic                         m1_hmastlock,
    input  logic [HASTI_TRANS_WIDTH-1:0] m1_htrans,
    input  logic [HASTI_BUS_WIDTH-1:0]   m1_hwdata,
    output logic [HASTI_BUS_WIDTH-1:0]   m1_hrdata,
    output logic                         m1_hready,
    output logic [HASTI_RESP_WIDTH-1:0]  m1_hresp,

    // slave
    output logic [HASTI_ADDR_WIDTH-1:0]  s_haddr,
    output logic                         s_hwrite,
    output logic [HASTI_SIZE_WIDTH-1:0]  s_hsize,
    output logic [HASTI_BURST_WIDTH-1:0] s_hburst,
    output logic [HASTI_PROT_WIDTH-1:0]  s_hprot,
    output logic                         s_hmastlock,
    output logic [HASTI_TRANS_WIDTH-1:0] s_htrans,
    output logic [HASTI_BUS_WIDTH-1:0]   s_hwdata,
    input  logic [HASTI_BUS_WIDTH-1:0]   s_hrdata,
    input  logic                         s_hready,
    input  logic [HASTI_RESP_WIDTH-1:0]  s_hresp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2
    } mst_state_t;

    typedef struct packed {
        logic [HASTI_ADDR_WIDTH-1:0]  addr;
        logic                         write;
        logic [HASTI_SIZE_WIDTH-1:0]  size;
        logic [HASTI_BURST_WIDTH-1:0] burst;
        logic [HASTI_PROT_WIDTH-1:0]  prot;
        logic                         mastlock;
    } req_t;

    // registered state
    mst_state_t state_q [2];
    req_t       buf_q   [2];
    logic       owner_vld_q;
    logic       owner_m1_q;
    logic       last_m1_q;
    req_t       hold_q;

    // per-master combinational view
    logic [HASTI_TRANS_WIDTH-1:0] htrans   [2];
    req_t                         live_req [2];
    logic [1:0]                   hready_int;
    logic [1:0]                   live;
    logic [1:0]                   cand;

    // arbitration result
    logic [1:0] grant_oh;
    logic       grant_vld;
    req_t       sel_req;
    req_t       addr_out;

    // Gather the two master address phases into indexable form.
    always_comb begin
        htrans[0]            = m0_htrans;
        htrans[1]            = m1_htrans;
        live_req[0].addr     = m0_haddr;
        live_req[0].write    = m0_hwrite;
        live_req[0].size     = m0_hsize;
        live_req[0].burst    = m0_hburst;
        live_req[0].prot     = m0_hprot;
        live_req[0].mastlock = m0_hmastlock;
        live_req[1].addr     = m1_haddr;
        live_req[1].write    = m1_hwrite;
        live_req[1].size     = m1_hsize;
        live_req[1].burst    = m1_hburst;
        live_req[1].prot     = m1_hprot;
        live_req[1].mastlock = m1_hmastlock;
    end

    // Per-master ready, live-request and candidate decode.
    always_comb begin
        hready_int = '0;
        live       = '0;
        cand       = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            case (state_q[i])
                ST_IDLE: hready_int[i] = 1'b1;
                ST_WAIT: hready_int[i] = 1'b0;
                default: hready_int[i] = s_hready;
            endcase
            // BUSY and SEQ are not supported and fall through as idle
            live[i] = (htrans[i] == HASTI_TRANS_NONSEQ) && hready_int[i];
            cand[i] = (state_q[i] == ST_WAIT) || live[i];
        end
    end

    // Round-robin grant; nothing is issued while the slave stalls or in reset.
    always_comb begin
        grant_oh = '0;
        if (s_hready && !reset) begin
            if (cand == 2'b11) begin
                grant_oh = last_m1_q ? 2'b01 : 2'b10;
            end else begin
                grant_oh = cand;
            end
        end
        grant_vld = |grant_oh;
    end

    // Granted request comes from the buffer when replaying, else straight through.
    always_comb begin
        if (grant_oh[1]) begin
            sel_req = (state_q[1] == ST_WAIT) ? buf_q[1] : live_req[1];
        end else begin
            sel_req = (state_q[0] == ST_WAIT) ? buf_q[0] : live_req[0];
        end
        if (reset) begin
            addr_out = '0;
        end else if (grant_vld) begin
            addr_out = sel_req;
        end else begin
            addr_out = hold_q;
        end
    end

    // Slave and master output drive.
    always_comb begin
        s_haddr     = addr_out.addr;
        s_hwrite    = addr_out.write;
        s_hsize     = addr_out.size;
        s_hburst    = addr_out.burst;
        s_hprot     = addr_out.prot;
        s_hmastlock = addr_out.mastlock;
        s_htrans    = grant_vld ? HASTI_TRANS_NONSEQ : HASTI_TRANS_IDLE;

        s_hwdata = '0;
        if (!reset && owner_vld_q) begin
            s_hwdata = owner_m1_q ? m1_hwdata : m0_hwdata;
        end

        m0_hrdata = s_hrdata;
        m1_hrdata = s_hrdata;
        m0_hready = reset ? 1'b1 : hready_int[0];
        m1_hready = reset ? 1'b1 : hready_int[1];
        m0_hresp  = (!reset && owner_vld_q && !owner_m1_q) ? s_hresp : HASTI_RESP_OKAY;
        m1_hresp  = (!reset && owner_vld_q &&  owner_m1_q) ? s_hresp : HASTI_RESP_OKAY;
    end

    // Master state machines, request buffers, data-phase owner and RR pointer.
    always_ff @(posedge hclk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= ST_IDLE;
                buf_q[i]   <= '0;
            end
            owner_vld_q <= 1'b0;
            owner_m1_q  <= 1'b0;
            last_m1_q   <= 1'b1;
            hold_q      <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (s_hready) begin
                    if (grant_oh[i]) begin
                        state_q[i] <= ST_DATA;
                    end else if (live[i]) begin
                        // a live request that lost arbitration; WAIT masters
                        // are never live, so their buffer is never touched here
                        buf_q[i]   <= live_req[i];
                        state_q[i] <= ST_WAIT;
                    end else if (state_q[i] != ST_WAIT) begin
                        state_q[i] <= ST_IDLE;
                    end
                end else if (state_q[i] == ST_IDLE && live[i]) begin
                    buf_q[i]   <= live_req[i];
                    state_q[i] <= ST_WAIT;
                end
            end
            if (s_hready) begin
                owner_vld_q <= grant_vld;
                owner_m1_q  <= grant_oh[1];
            end
            if (grant_vld) begin
                last_m1_q <= grant_oh[1];
                hold_q    <= sel_req;
            end
        end
    end

endmodule

// File: tb/tb_vscale_hasti_2to1_arbiter.sv
// Directed bench for vscale_hasti_2to1_arbiter: a cycle-by-cycle vector
// table followed by hand-written round-robin and reset-during-wait sequences.

module tb_vscale_hasti_2to1_arbiter;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic        reset;
    logic [31:0] m0_haddr, m1_haddr, s_haddr;
    logic        m0_hwrite, m1_hwrite, s_hwrite;
    logic [2:0]  m0_hsize, m1_hsize, s_hsize;
    logic [2:0]  m0_hburst, m1_hburst, s_hburst;
    logic [3:0]  m0_hprot, m1_hprot, s_hprot;
    logic        m0_hmastlock, m1_hmastlock, s_hmastlock;
    logic [1:0]  m0_htrans, m1_htrans, s_htrans;
    logic [31:0] m0_hwdata, m1_hwdata, s_hwdata;
    logic [31:0] m0_hrdata, m1_hrdata, s_hrdata;
    logic        m0_hready, m1_hready, s_hready;
    logic        m0_hresp, m1_hresp, s_hresp;

    vscale_hasti_2to1_arbiter dut (
        .hclk(hclk), .reset(reset),
        .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
        .m0_hburst(m0_hburst), .m0_hprot(m0_hprot), .m0_hmastlock(m0_hmastlock),
        .m0_htrans(m0_htrans), .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata),
        .m0_hready(m0_hready), .m0_hresp(m0_hresp),
        .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
        .m1_hburst(m1_hburst), .m1_hprot(m1_hprot), .m1_hmastlock(m1_hmastlock),
        .m1_htrans(m1_htrans), .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata),
        .m1_hready(m1_hready), .m1_hresp(m1_hresp),
        .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hmastlock(s_hmastlock),
        .s_htrans(s_htrans), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata),
        .s_hready(s_hready), .s_hresp(s_hresp)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  t0;
        logic [31:0] a0;
        logic        w0;
        logic [31:0] d0;
        logic [1:0]  t1;
        logic [31:0] a1;
        logic        w1;
        logic [31:0] d1;
        logic        shr;
        logic [31:0] srd;
        logic        sresp;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
        logic        e_write;
        logic [2:0]  e_size;
        logic [31:0] e_wdata;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_resp0;
        logic        e_resp1;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
    endtask

    function automatic vec_t mk(
        input logic [31:0] rst, t0, a0, w0, d0, t1, a1, w1, d1, shr, srd, sresp,
        input logic [31:0] e_trans, e_addr, e_write, e_size, e_wdata,
        input logic [31:0] e_rdy0, e_rdy1, e_resp0, e_resp1);
        vec_t v;
        v.rst = rst[0];   v.t0 = t0[1:0]; v.a0 = a0; v.w0 = w0[0]; v.d0 = d0;
        v.t1 = t1[1:0];   v.a1 = a1;      v.w1 = w1[0]; v.d1 = d1;
        v.shr = shr[0];   v.srd = srd;    v.sresp = sresp[0];
        v.e_trans = e_trans[1:0]; v.e_addr = e_addr; v.e_write = e_write[0];
        v.e_size = e_size[2:0];   v.e_wdata = e_wdata;
        v.e_rdy0 = e_rdy0[0]; v.e_rdy1 = e_rdy1[0];
        v.e_resp0 = e_resp0[0]; v.e_resp1 = e_resp1[0];
        return v;
    endfunction

    task automatic drive(input logic rst, input logic [1:0] t0, input logic [31:0] a0,
                         input logic w0, input logic [31:0] d0, input logic [1:0] t1,
                         input logic [31:0] a1, input logic w1, input logic [31:0] d1,
                         input logic shr, input logic [31:0] srd, input logic sresp);
        reset = rst;
        m0_htrans = t0; m0_haddr = a0; m0_hwrite = w0; m0_hwdata = d0;
        m1_htrans = t1; m1_haddr = a1; m1_hwrite = w1; m1_hwdata = d1;
        s_hready = shr; s_hrdata = srd; s_hresp = sresp;
    endtask

    task automatic next_cycle();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        // fixed per-master attributes so the slave-side mux is observable
        m0_hsize = 3'd2; m0_hburst = 3'd0; m0_hprot = 4'h3; m0_hmastlock = 1'b0;
        m1_hsize = 3'd0; m1_hburst = 3'd1; m1_hprot = 4'hC; m1_hmastlock = 1'b1;

        //            rst t0 a0     w0 d0            t1 a1     w1 d1            shr srd           sresp | trans addr   wr sz wdata         r0 r1 p0 p1
        vecs[0]  = mk(1,  0, 0,     0, 0,            0, 0,     0, 0,            1, 32'hAAAA0000, 1,      0, 0,      0, 0, 0,            1, 1, 0, 0);
        vecs[1]  = mk(0,  0, 0,     0, 0,            0, 0,     0, 0,            1, 32'hAAAA0001, 1,      0, 0,      0, 0, 0,            1, 1, 0, 0);
        // single read by m0
        vecs[2]  = mk(0,  2, 32'h10,0, 32'h11111111, 0, 0,     0, 0,            1, 0,            0,      2, 32'h10, 0, 2, 0,            1, 1, 0, 0);
        vecs[3]  = mk(0,  0, 0,     0, 32'h22222222, 0, 0,     0, 0,            1, 32'hDEADBEEF, 1,      0, 32'h10, 0, 2, 32'h22222222, 1, 1, 1, 0);
        // reset to re-arm the tie pointer, then simultaneous requests
        vecs[4]  = mk(1,  0, 0,     0, 0,            0, 0,     0, 0,            1, 0,            1,      0, 0,      0, 0, 0,            1, 1, 0, 0);
        vecs[5]  = mk(0,  2, 32'h4, 1, 32'h33333333, 2, 32'h8, 0, 32'h99999999, 1, 0,            0,      2, 32'h4,  1, 2, 0,            1, 1, 0, 0);
        vecs[6]  = mk(0,  0, 0,     0, 32'h44444444, 0, 0,     0, 0,            1, 0,            1,      2, 32'h8,  0, 0, 32'h44444444, 1, 0, 1, 0);
        vecs[7]  = mk(0,  0, 0,     0, 0,            0, 0,     0, 32'h55555555, 1, 32'hCAFEF00D, 0,      0, 32'h8,  0, 0, 32'h55555555, 1, 1, 0, 0);
        // slave stall during m0 data phase while m1 issues
        vecs[8]  = mk(0,  2, 32'h20,0, 0,            0, 0,     0, 0,            1, 0,            0,      2, 32'h20, 0, 2, 0,            1, 1, 0, 0);
        vecs[9]  = mk(0,  0, 0,     0, 32'h66666666, 2, 32'h30,1, 0,            0, 0,            0,      0, 32'h20, 0, 2, 32'h66666666, 0, 1, 0, 0);
        vecs[10] = mk(0,  0, 0,     0, 32'h66666666, 2, 32'h30,1, 0,            0, 0,            1,      0, 32'h20, 0, 2, 32'h66666666, 0, 0, 1, 0);
        vecs[11] = mk(0,  0, 0,     0, 32'h66666666, 0, 0,     0, 0,            1, 0,            0,      2, 32'h30, 1, 0, 32'h66666666, 1, 0, 0, 0);
        vecs[12] = mk(0,  0, 0,     0, 0,            0, 0,     0, 32'h77777777, 1, 0,            1,      0, 32'h30, 1, 0, 32'h77777777, 1, 1, 0, 1);
        // BUSY and SEQ codes behave as idle
        vecs[13] = mk(0,  1, 32'h40,0, 0,            3, 32'h44,0, 0,            1, 0,            0,      0, 32'h30, 1, 0, 0,            1, 1, 0, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].t0, vecs[i].a0, vecs[i].w0, vecs[i].d0,
                  vecs[i].t1, vecs[i].a1, vecs[i].w1, vecs[i].d1,
                  vecs[i].shr, vecs[i].srd, vecs[i].sresp);
            #3;
            chk($sformatf("v%0d.s_htrans", i),  32'(s_htrans),  32'(vecs[i].e_trans));
            chk($sformatf("v%0d.s_haddr", i),   s_haddr,        vecs[i].e_addr);
            chk($sformatf("v%0d.s_hwrite", i),  32'(s_hwrite),  32'(vecs[i].e_write));
            chk($sformatf("v%0d.s_hsize", i),   32'(s_hsize),   32'(vecs[i].e_size));
            chk($sformatf("v%0d.s_hwdata", i),  s_hwdata,       vecs[i].e_wdata);
            chk($sformatf("v%0d.m0_hready", i), 32'(m0_hready), 32'(vecs[i].e_rdy0));
            chk($sformatf("v%0d.m1_hready", i), 32'(m1_hready), 32'(vecs[i].e_rdy1));
            chk($sformatf("v%0d.m0_hresp", i),  32'(m0_hresp),  32'(vecs[i].e_resp0));
            chk($sformatf("v%0d.m1_hresp", i),  32'(m1_hresp),  32'(vecs[i].e_resp1));
            chk($sformatf("v%0d.m0_hrdata", i), m0_hrdata,      vecs[i].srd);
            chk($sformatf("v%0d.m1_hrdata", i), m1_hrdata,      vecs[i].srd);
            next_cycle();
        end

        // Round-robin: both masters request every cycle they are ready.
        // Grants alternate m0,m1,...; each replayed address is the one the
        // master presented on the cycle it lost.
        for (int k = 0; k < 8; k++) begin
            logic [31:0] exp_addr;
            if (k < 6) drive(0, 2, 32'h100 + 32'(k) * 4, 0, 0, 2, 32'h200 + 32'(k) * 4, 0, 0, 1, 0, 0);
            else       drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            #3;
            if (k < 7) begin
                if (k == 0)          exp_addr = 32'h100;
                else if (k % 2 == 1) exp_addr = 32'h200 + 32'(k - 1) * 4;
                else                 exp_addr = 32'h100 + 32'(k - 1) * 4;
                chk($sformatf("rr%0d.s_htrans", k),     32'(s_htrans),    32'd2);
                chk($sformatf("rr%0d.s_haddr", k),      s_haddr,          exp_addr);
                chk($sformatf("rr%0d.s_hmastlock", k),  32'(s_hmastlock), 32'(k % 2));
            end else begin
                chk($sformatf("rr%0d.s_htrans", k),     32'(s_htrans),    32'd0);
            end
            if (k < 6) begin
                chk($sformatf("rr%0d.m0_hready", k), 32'(m0_hready), 32'((k == 0) || (k % 2 == 1)));
                chk($sformatf("rr%0d.m1_hready", k), 32'(m1_hready), 32'(k % 2 == 0));
            end
            next_cycle();
        end

        // Reset while m1 waits: the buffered 0x3C0 must never reach the slave.
        drive(0, 2, 32'h300, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        #3;
        chk("rst.a.s_htrans", 32'(s_htrans), 32'd2);
        chk("rst.a.s_haddr",  s_haddr,       32'h300);
        next_cycle();
        drive(0, 0, 0, 0, 0, 2, 32'h3C0, 0, 0, 0, 0, 0);
        #3;
        chk("rst.b.s_htrans",  32'(s_htrans),  32'd0);
        chk("rst.b.m1_hready", 32'(m1_hready), 32'd1);
        chk("rst.b.m0_hready", 32'(m0_hready), 32'd0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 2, 32'h3C0, 0, 0, 1, 0, 0);
        #3;
        chk("rst.c.s_htrans",  32'(s_htrans),  32'd0);
        chk("rst.c.s_haddr",   s_haddr,        32'h0);
        chk("rst.c.m1_hready", 32'(m1_hready), 32'd1);
        chk("rst.c.m0_hready", 32'(m0_hready), 32'd1);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            #3;
            chk($sformatf("rst.d%0d.s_htrans", k),  32'(s_htrans),  32'd0);
            chk($sformatf("rst.d%0d.s_haddr", k),   s_haddr,        32'h0);
            chk($sformatf("rst.d%0d.m1_hready", k), 32'(m1_hready), 32'd1);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
